assoc_cache: RTL

Parametrised N-way set-associative, tag-only cache model for the cache simulator. It accepts one memory reference at a time over a valid/ready handshake and returns hit/miss plus the way used. On a miss it allocates the line using true-LRU replacement, and it keeps saturating hit/miss statistics. It replaces the fixed 16-set, direct-enable cache top and adds associativity, replacement, flush and statistics.

---
 rtl/cache_sim_pkg.sv | 24 ++
 rtl/lru_age_update.sv | 31 +++
 rtl/assoc_cache.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/cache_sim_pkg.sv
// State encoding and address-field width helpers shared by the cache simulator blocks.
package cache_sim_pkg;

   localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
   localparam logic [1:0] ST_LOOKUP_ENC = 2'd1;
   localparam logic [1:0] ST_FILL_ENC   = 2'd2;
   localparam logic [1:0] ST_FLUSH_ENC  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = ST_IDLE_ENC,
      ST_LOOKUP = ST_LOOKUP_ENC,
      ST_FILL   = ST_FILL_ENC,
      ST_FLUSH  = ST_FLUSH_ENC
   } state_t;

   function automatic int tag_width(input int addr_w, input int offset_w, input int index_w);
      return addr_w - offset_w - index_w;
   endfunction

   function automatic int way_width(input int ways);
      return $clog2(ways);
   endfunction

endpackage

// File: rtl/lru_age_update.sv
// True-LRU age vector update for one set: accessed way becomes age 0, younger ways age by one.
module lru_age_update #(
   parameter int WAYS  = 4,
   parameter int WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS-1:0][WAY_W-1:0] ages,
   input  logic [WAY_W-1:0]           way,
   output logic [WAYS-1:0][WAY_W-1:0] ages_next,
   output logic [WAY_W-1:0]           lru_way
);
   logic [WAY_W-1:0] acc_age;

   assign acc_age = ages[way];

   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_age
         assign ages_next[gi] = (WAY_W'(gi) == way)  ? '0 :
                                (ages[gi] < acc_age) ? ages[gi] + 1'b1 :
                                                       ages[gi];
      end
   endgenerate

   // Ages form a permutation, so exactly one way carries the oldest age.
   always_comb begin
      lru_way = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (ages[i] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(i);
      end
   end

endmodule

// File: rtl/assoc_cache.sv
// N-way set-associative tag-only cache: valid/ready lookups, true-LRU allocation,
// sequential flush and saturating hit/miss statistics.
module assoc_cache
   import cache_sim_pkg::*;
#(
   parameter int ADDR_W   = 32,
   parameter int OFFSET_W = 3,
   parameter int INDEX_W  = 4,
   parameter int WAYS     = 4,
   parameter int CNT_W    = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic                    flush,
   output logic                    resp_valid,
   output logic                    resp_hit,
   output logic [$clog2(WAYS)-1:0] resp_way,
   output logic [CNT_W-1:0]        hit_count,
   output logic [CNT_W-1:0]        miss_count
);
   localparam int SETS  = 2 ** INDEX_W;
   localparam int TAG_W = tag_width(ADDR_W, OFFSET_W, INDEX_W);
   localparam int WAY_W = way_width(WAYS);

   typedef logic [WAYS-1:0][WAY_W-1:0] ages_t;

   state_t             state_reg, state_next;
   logic [TAG_W-1:0]   tag_reg;
   logic [INDEX_W-1:0] index_reg;
   logic [WAY_W-1:0]   victim_reg;
   logic [INDEX_W-1:0] flush_ptr_reg;
   logic               hit_hold_reg;
   logic [WAY_W-1:0]   way_hold_reg;
   logic [CNT_W-1:0]   hit_count_reg, miss_count_reg;

   logic [WAYS-1:0]    valid_reg [SETS];
   ages_t              age_reg   [SETS];
   logic [TAG_W-1:0]   tag_mem   [SETS][WAYS];

   ages_t              age_init, ages_next;
   logic [WAYS-1:0]    match;
   logic               hit, free_found;
   logic [WAY_W-1:0]   hit_way, free_way, lru_way, victim, acc_way, lookup_way;
   logic               offset_unused;

   assign offset_unused = ^req_addr[OFFSET_W-1:0];

   generate
      for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
         assign age_init[gi] = WAY_W'(gi);
         assign match[gi]    = valid_reg[index_reg][gi] && (tag_mem[index_reg][gi] == tag_reg);
      end
   endgenerate

   always_comb begin
      hit        = 1'b0;
      hit_way    = '0;
      free_found = 1'b0;
      free_way   = '0;
      for (int i = 0; i < WAYS; i++) begin
         if (match[i]) begin
            hit     = 1'b1;
            hit_way = WAY_W'(i);
         end
      end
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (!valid_reg[index_reg][i]) begin
            free_found = 1'b1;
            free_way   = WAY_W'(i);
         end
      end
   end

   assign victim     = free_found ? free_way : lru_way;
   assign lookup_way = hit ? hit_way : victim;
   // FILL ages the way chosen during LOOKUP; LOOKUP ages the way that hit.
   assign acc_way    = (state_reg == ST_FILL) ? victim_reg : hit_way;

   lru_age_update #(
      .WAYS  (WAYS),
      .WAY_W (WAY_W)
   ) u_lru (
      .ages      (age_reg[index_reg]),
      .way       (acc_way),
      .ages_next (ages_next),
      .lru_way   (lru_way)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:   if (flush) state_next = ST_FLUSH;
                    else if (req_valid) state_next = ST_LOOKUP;
         ST_LOOKUP: state_next = hit ? ST_IDLE : ST_FILL;
         ST_FILL:   state_next = ST_IDLE;
         ST_FLUSH:  if (flush_ptr_reg == INDEX_W'(SETS - 1)) state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state_reg == ST_IDLE);
      resp_valid = (state_reg == ST_LOOKUP);
      resp_hit   = hit_hold_reg;
      resp_way   = way_hold_reg;
      if (state_reg == ST_LOOKUP) begin
         resp_hit = hit;
         resp_way = lookup_way;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= ST_IDLE;
         tag_reg        <= '0;
         index_reg      <= '0;
         victim_reg     <= '0;
         flush_ptr_reg  <= '0;
         hit_hold_reg   <= 1'b0;
         way_hold_reg   <= '0;
         hit_count_reg  <= '0;
         miss_count_reg <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_reg[s] <= '0;
            age_reg[s]   <= age_init;
         end
      end else begin
         state_reg <= state_next;
         case (state_reg)
            ST_IDLE: begin
               if (!flush && req_valid) begin
                  tag_reg   <= req_addr[ADDR_W-1 -: TAG_W];
                  index_reg <= req_addr[OFFSET_W +: INDEX_W];
               end
            end
            ST_LOOKUP: begin
               hit_hold_reg <= hit;
               way_hold_reg <= lookup_way;
               victim_reg   <= victim;
               if (hit) begin
                  age_reg[index_reg] <= ages_next;
                  if (hit_count_reg != {CNT_W{1'b1}}) hit_count_reg <= hit_count_reg + 1'b1;
               end else if (miss_count_reg != {CNT_W{1'b1}}) begin
                  miss_count_reg <= miss_count_reg + 1'b1;
               end
            end
            ST_FILL: begin
               valid_reg[index_reg][victim_reg] <= 1'b1;
               age_reg[index_reg]               <= ages_next;
            end
            ST_FLUSH: begin
               valid_reg[flush_ptr_reg] <= '0;
               age_reg[flush_ptr_reg]   <= age_init;
               flush_ptr_reg            <= flush_ptr_reg + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Tags need no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (rst_n && state_reg == ST_FILL) tag_mem[index_reg][victim_reg] <= tag_reg;
   end

   assign hit_count  = hit_count_reg;
   assign miss_count = miss_count_reg;

endmodule
